flag_cond_eval: RTL



---
 rtl/flag_cond_eval.sv | 191 +++++++++++++++++++
 1 files changed

// File: rtl/flag_cond_eval.sv
// ---------------------------------------------------------------------------
// flag_cond_eval
//
// Purpose:
//   Consumer side of the ALU status-flag path. Captures the Z/O/C/N flags
//   that come with each ALU result into an architectural flag register. It
//   evaluates 4-bit branch/predicate condition codes against those flags and
//   returns a taken/not-taken decision over a registered valid/ready
//   response channel.
//
// Parameters:
//   BYPASS       1: a request accepted in the same cycle as flag_we sees the
//                incoming flags. 0: requests always see the registered flags.
//   RESET_FLAGS  reset value of the flag register, ordered {n,z,c,o}.
//
// Ports:
//   clk, reset            rising-edge clock, synchronous active-high reset
//   flag_we               load {n_in,z_in,c_in,o_in} into the flag register
//   z_in/o_in/c_in/n_in   zero / signed overflow / carry / negative from ALU
//   req_valid, req_cond   condition evaluation request and 4-bit code
//   req_ready             a request can be accepted this cycle
//   rsp_valid, rsp_taken  registered decision; rsp_taken is meaningful only
//                         while rsp_valid is high
//   rsp_ready             consumer accepts the response
//   flags_out             registered flags {n,z,c,o}
//   eval_count            accepted requests whose result was taken (wraps)
//   o_state               debug view of the response FSM (0 IDLE, 1 RESP)
//   flag_save, flag_restore  only with FLAG_SHADOW_EN (see below)
//
// Handshake:
//   A transfer happens on a channel in any cycle where both its valid and
//   its ready are high at the rising edge. A valid that is not matched by
//   ready is not remembered: the requester keeps req_valid/req_cond stable
//   until it sees req_ready. rsp_valid/rsp_taken stay stable until
//   rsp_ready is seen.
//
// Optional feature (macro FLAG_SHADOW_EN):
//   Adds flag_save/flag_restore and a 4-bit shadow register. Save copies the
//   registered flags into the shadow. Restore loads the flag register from
//   the shadow and overrides flag_we. Save together with restore swaps the
//   two registers. The bypass path only ever forwards ALU inputs, so
//   restored values become visible to evaluation one cycle later.
// ---------------------------------------------------------------------------
module flag_cond_eval #(
  parameter bit         BYPASS      = 1'b1,
  parameter logic [3:0] RESET_FLAGS = 4'b0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        flag_we,
  input  logic        z_in,
  input  logic        o_in,
  input  logic        c_in,
  input  logic        n_in,
  input  logic        req_valid,
  input  logic [3:0]  req_cond,
  output logic        req_ready,
  output logic        rsp_valid,
  output logic        rsp_taken,
  input  logic        rsp_ready,
  output logic [3:0]  flags_out,
  output logic [15:0] eval_count,
`ifdef FLAG_SHADOW_EN
  input  logic        flag_save,
  input  logic        flag_restore,
`endif
  output logic        o_state
);

  typedef enum logic {
    IDLE = 1'b0,
    RESP = 1'b1
  } state_t;

  state_t      r_state;
  state_t      w_state_next;
  logic [3:0]  r_flags;
  logic        r_rsp_taken;
  logic [15:0] r_eval_count;
  logic [3:0]  w_flags_in;
  logic [3:0]  w_eff_flags;
  logic        w_accept;
  logic        w_result;

`ifdef FLAG_SHADOW_EN
  logic [3:0]  r_shadow;
`endif

  // Flag vectors are packed {n,z,c,o}.
  function automatic logic cond_eval(input logic [3:0] cond, input logic [3:0] f);
    logic n, z, c, o;
    n = f[3];
    z = f[2];
    c = f[1];
    o = f[0];
    case (cond)
      4'd0:    cond_eval = z;
      4'd1:    cond_eval = !z;
      4'd2:    cond_eval = c;
      4'd3:    cond_eval = !c;
      4'd4:    cond_eval = n;
      4'd5:    cond_eval = !n;
      4'd6:    cond_eval = o;
      4'd7:    cond_eval = !o;
      4'd8:    cond_eval = c & !z;
      4'd9:    cond_eval = !c | z;
      4'd10:   cond_eval = (n == o);
      4'd11:   cond_eval = (n != o);
      4'd12:   cond_eval = !z & (n == o);
      4'd13:   cond_eval = z | (n != o);
      4'd14:   cond_eval = 1'b1;
      default: cond_eval = 1'b0;
    endcase
  endfunction

  assign w_flags_in  = {n_in, z_in, c_in, o_in};
  assign w_eff_flags = (BYPASS && flag_we) ? w_flags_in : r_flags;
  assign w_result    = cond_eval(req_cond, w_eff_flags);

  // A pending response that is being consumed this cycle frees the slot,
  // so back-to-back requests flow at one per cycle.
  assign rsp_valid  = (r_state == RESP);
  assign req_ready  = !rsp_valid | rsp_ready;
  assign w_accept   = req_valid & req_ready;

  assign rsp_taken  = r_rsp_taken;
  assign flags_out  = r_flags;
  assign eval_count = r_eval_count;
  assign o_state    = r_state;

  // Next-state logic for the response FSM.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE: begin
        if (w_accept) w_state_next = RESP;
      end
      RESP: begin
        if (rsp_ready && !w_accept) w_state_next = IDLE;
      end
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Response data. This register only loads on acceptance, so a stalled
  // response is frozen no matter how the flags change meanwhile.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_rsp_taken  <= 1'b0;
      r_eval_count <= 16'd0;
    end else if (w_accept) begin
      r_rsp_taken <= w_result;
      if (w_result) r_eval_count <= r_eval_count + 16'd1;
    end
  end

`ifdef FLAG_SHADOW_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      r_flags  <= RESET_FLAGS;
      r_shadow <= RESET_FLAGS;
    end else begin
      // The shadow takes the flags as they were before any restore, which
      // makes save + restore in one cycle a swap.
      if (flag_save) r_shadow <= r_flags;
      if (flag_restore) begin
        r_flags <= r_shadow;
      end else if (flag_we) begin
        r_flags <= w_flags_in;
      end
    end
  end
`else
  always_ff @(posedge clk) begin
    if (reset) begin
      r_flags <= RESET_FLAGS;
    end else if (flag_we) begin
      r_flags <= w_flags_in;
    end
  end
`endif

endmodule
